uart_rx_ctrl: RTL and testbench

UART_RX_CTRL -- requirements
Module: uart_rx_ctrl

---
 rtl/uart_rx_ctrl.sv | 104 ++++++++++
 tb/tb_uart_rx_ctrl.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: sequences start/data/parity/stop bit timing from a
// latched prescale and drives registered strobes to the external bit checkers.
module uart_rx_ctrl #(
   parameter int DATA_WIDTH  = 8,
   parameter int PRESC_WIDTH = 6
) (
   input  logic                          CLK,
   input  logic                          RST,
   input  logic                          RX_IN,
   input  logic                          PAR_EN,
   input  logic [PRESC_WIDTH-1:0]        Prescale,
   input  logic                          strt_glitch,
   input  logic                          par_err,
   input  logic                          stp_err,
   output logic                          strt_chk_en,
   output logic                          deser_en,
   output logic                          par_chk_en,
   output logic                          stp_chk_en,
   output logic [$clog2(DATA_WIDTH):0]   bit_cnt,
   output logic                          data_valid,
   output logic                          frame_par_err,
   output logic                          frame_stp_err,
   output logic                          busy
);

   localparam int CNT_W = $clog2(DATA_WIDTH) + 1;
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);
   localparam logic [PRESC_WIDTH-1:0] MIN_PRESC = PRESC_WIDTH'(4);

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, DONE} state_t;

   state_t                 state, state_n;
   logic [PRESC_WIDTH-1:0] presc_lat, presc_n, edge_cnt, edge_n, half_n;
   logic                   bit_state, bit_end, enter_start, sample_n;
   logic                   par_flag;

   // Prescale values too small to leave room for the checker response are raised.
   function automatic logic [PRESC_WIDTH-1:0] sat_presc(input logic [PRESC_WIDTH-1:0] p);
      return (p < MIN_PRESC) ? MIN_PRESC : p;
   endfunction

   always_ff @(posedge CLK) begin
      if (RST) state <= IDLE;
      else     state <= state_n;
   end

   always_comb begin
      state_n   = state;
      bit_state = (state == START) || (state == DATA) || (state == PARITY) || (state == STOP);
      bit_end   = bit_state && (edge_cnt == presc_lat - PRESC_WIDTH'(1));
      case (state)
         IDLE:    if (!RX_IN) state_n = START;
         START:   if (bit_end) state_n = strt_glitch ? IDLE : DATA;
         DATA:    if (bit_end && bit_cnt == LAST_BIT) state_n = PAR_EN ? PARITY : STOP;
         PARITY:  if (bit_end) state_n = STOP;
         STOP:    if (bit_end) state_n = DONE;
         DONE:    state_n = RX_IN ? IDLE : START;
         default: state_n = IDLE;
      endcase
      enter_start = (state_n == START) && (state != START);
      presc_n     = enter_start ? sat_presc(Prescale) : presc_lat;
      edge_n      = (bit_state && !bit_end) ? edge_cnt + PRESC_WIDTH'(1) : '0;
      half_n      = presc_n >> 1;
      // Strobes are computed one cycle early so the registered copy lines up with mid-bit.
      sample_n    = (edge_n == half_n);
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         presc_lat     <= MIN_PRESC;
         edge_cnt      <= '0;
         bit_cnt       <= '0;
         par_flag      <= 1'b0;
         strt_chk_en   <= 1'b0;
         deser_en      <= 1'b0;
         par_chk_en    <= 1'b0;
         stp_chk_en    <= 1'b0;
         data_valid    <= 1'b0;
         frame_par_err <= 1'b0;
         frame_stp_err <= 1'b0;
         busy          <= 1'b0;
      end else begin
         presc_lat <= presc_n;
         edge_cnt  <= edge_n;
         if (enter_start)
            bit_cnt <= '0;
         else if (state == DATA && bit_end)
            bit_cnt <= bit_cnt + CNT_W'(1);
         if (enter_start)
            par_flag <= 1'b0;
         else if (state == PARITY && bit_end)
            par_flag <= par_err;
         strt_chk_en   <= (state_n == START)  && sample_n;
         deser_en      <= (state_n == DATA)   && sample_n;
         par_chk_en    <= (state_n == PARITY) && sample_n;
         stp_chk_en    <= (state_n == STOP)   && sample_n;
         data_valid    <= (state_n == DONE) && !par_flag && !stp_err;
         frame_par_err <= (state_n == DONE) && par_flag;
         frame_stp_err <= (state_n == DONE) && stp_err;
         busy          <= (state_n != IDLE);
      end
   end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Bench for uart_rx_ctrl: drives serial frames, emulates the bit checkers and
// compares every end-of-frame pulse against a queue of expected frames.
module tb_uart_rx_ctrl;

   logic       CLK = 1'b0;
   logic       RST = 1'b1;
   logic       RX_IN = 1'b1;
   logic       PAR_EN = 1'b0;
   logic [5:0] Prescale = 6'd8;
   logic       strt_glitch = 1'b0;
   logic       par_err = 1'b0;
   logic       stp_err = 1'b0;
   logic       strt_chk_en, deser_en, par_chk_en, stp_chk_en;
   logic [3:0] bit_cnt;
   logic       data_valid, frame_par_err, frame_stp_err, busy;

   uart_rx_ctrl #(.DATA_WIDTH(8), .PRESC_WIDTH(6)) dut (
      .CLK(CLK), .RST(RST), .RX_IN(RX_IN), .PAR_EN(PAR_EN), .Prescale(Prescale),
      .strt_glitch(strt_glitch), .par_err(par_err), .stp_err(stp_err),
      .strt_chk_en(strt_chk_en), .deser_en(deser_en), .par_chk_en(par_chk_en),
      .stp_chk_en(stp_chk_en), .bit_cnt(bit_cnt), .data_valid(data_valid),
      .frame_par_err(frame_par_err), .frame_stp_err(frame_stp_err), .busy(busy)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      int         p;
      int         pe;
      logic [7:0] d;
      bit         par_bad;
      bit         stp_bad;
      bit         b2b;
   } exp_t;

   exp_t       sb[$];
   int         n_checks = 0;
   int         n_fail = 0;
   int         cyc = 0;
   int         start_cyc, last_done, last_deser;
   int         n_deser, n_par, n_stp, deser_total = 0;
   logic [7:0] shreg;
   bit         glitch_mode = 1'b0;

   task automatic chk(input string tag, input int got, input int exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0d exp=%0d (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   always @(posedge CLK) cyc <= cyc + 1;

   // Checker emulation and output monitor share one process to keep ordering fixed.
   always @(negedge CLK) begin
      exp_t e;
      chk("onehot", int'($countones({strt_chk_en, deser_en, par_chk_en, stp_chk_en,
                                     data_valid, frame_par_err, frame_stp_err}) <= 1), 1);
      if (strt_chk_en) begin
         strt_glitch = glitch_mode;
         par_err = 1'b0;
         stp_err = 1'b0;
         n_deser = 0; n_par = 0; n_stp = 0; shreg = '0;
         if (sb.size() > 0) begin
            start_cyc = cyc - sb[0].p / 2;
            if (sb[0].b2b) chk("b2b_gap", start_cyc - last_done, 1);
         end
      end
      if (deser_en) begin
         deser_total++;
         if (sb.size() > 0 && n_deser > 0) chk("deser_gap", cyc - last_deser, sb[0].p);
         n_deser++;
         last_deser = cyc;
         shreg = {RX_IN, shreg[7:1]};
      end
      if (par_chk_en) begin
         n_par++;
         if (sb.size() > 0) par_err = sb[0].par_bad;
      end
      if (stp_chk_en) begin
         n_stp++;
         if (sb.size() > 0) stp_err = sb[0].stp_bad;
      end
      if (data_valid || frame_par_err || frame_stp_err) begin
         if (sb.size() == 0) chk("unexpected_done", 1, 0);
         else begin
            e = sb.pop_front();
            chk("data_valid", data_valid, !(e.pe != 0 && e.par_bad) && !e.stp_bad);
            chk("frame_par_err", frame_par_err, e.pe != 0 && e.par_bad);
            chk("frame_stp_err", frame_stp_err, e.stp_bad);
            chk("data", shreg, e.d);
            chk("n_deser", n_deser, 8);
            chk("n_par", n_par, e.pe);
            chk("n_stp", n_stp, 1);
            chk("frame_len", cyc - start_cyc, e.p * (8 + 2 + e.pe));
            last_done = cyc;
         end
      end
   end

   task automatic drive_bit(input logic b, input int p);
      RX_IN = b;
      repeat (p) @(posedge CLK);
      #1;
   endtask

   // Caller must be 1ns after a rising edge.
   task automatic send_frame(input int p_line, input int pe, input logic [7:0] d,
                             input bit par_bad, input bit stp_bad, input int p_exp, input bit b2b);
      exp_t e;
      e.p = p_exp; e.pe = pe; e.d = d; e.par_bad = par_bad; e.stp_bad = stp_bad; e.b2b = b2b;
      sb.push_back(e);
      PAR_EN = (pe != 0);
      drive_bit(1'b0, p_line);
      for (int i = 0; i < 8; i++) drive_bit(d[i], p_line);
      if (pe != 0) drive_bit(^d, p_line);
      drive_bit(1'b1, p_line);
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 3000; i++) begin
         @(negedge CLK);
         if (!busy && sb.size() == 0) break;
      end
      chk("idle_timeout", int'(busy || sb.size() != 0), 0);
   endtask

   task automatic chk_all_zero(input string tag);
      chk(tag, int'({strt_chk_en, deser_en, par_chk_en, stp_chk_en, data_valid,
                     frame_par_err, frame_stp_err, busy}), 0);
      chk({tag, "_bit_cnt"}, bit_cnt, 0);
   endtask

   initial begin
      int t0, t1, d0;
      repeat (3) @(posedge CLK);
      @(negedge CLK);
      chk_all_zero("reset");
      RST = 1'b0;
      repeat (5) @(negedge CLK);
      chk("idle_busy", busy, 0);

      // Clean frame, then a parity error, then clean again.
      @(posedge CLK); #1;
      send_frame(8, 1, 8'h55, 0, 0, 8, 0);
      wait_idle();
      @(posedge CLK); #1;
      send_frame(8, 1, 8'h55, 1, 0, 8, 0);
      wait_idle();
      @(posedge CLK); #1;
      send_frame(8, 1, 8'h55, 0, 0, 8, 0);
      wait_idle();

      // No parity, stop error, slower bit rate.
      Prescale = 6'd16;
      @(posedge CLK); #1;
      send_frame(16, 0, 8'hA3, 0, 1, 16, 0);
      wait_idle();

      // Prescale below the minimum is raised to 4.
      Prescale = 6'd2;
      @(posedge CLK); #1;
      send_frame(4, 0, 8'h96, 0, 0, 4, 0);
      wait_idle();

      // Start glitch: short low pulse, checker reports glitch.
      Prescale = 6'd16;
      glitch_mode = 1'b1;
      d0 = deser_total;
      @(posedge CLK); #1;
      RX_IN = 1'b0;
      t0 = -1;
      for (int i = 0; i < 10; i++) begin
         @(negedge CLK);
         if (busy) begin t0 = cyc; break; end
      end
      chk("glitch_busy_rise", int'(t0 >= 0), 1);
      @(posedge CLK); @(posedge CLK); #1;
      RX_IN = 1'b1;
      t1 = -1;
      for (int i = 0; i < 100; i++) begin
         @(negedge CLK);
         if (!busy) begin t1 = cyc; break; end
      end
      chk("glitch_len", t1 - t0, 16);
      chk("glitch_deser", deser_total - d0, 0);
      glitch_mode = 1'b0;
      repeat (5) @(negedge CLK);
      chk("glitch_idle", busy, 0);

      // Reset in the middle of the data bits.
      Prescale = 6'd8;
      @(posedge CLK); #1;
      RX_IN = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(negedge CLK);
         if (bit_cnt == 4 && busy) break;
      end
      chk("rst_reach_bit4", bit_cnt, 4);
      RST = 1'b1;
      RX_IN = 1'b1;
      @(negedge CLK);
      chk_all_zero("rst_mid");
      RST = 1'b0;
      repeat (20) @(negedge CLK);
      chk("after_rst_idle", busy, 0);

      // Back-to-back frames; prescale change during the first applies to the second.
      Prescale = 6'd8;
      @(posedge CLK); #1;
      fork
         send_frame(8, 1, 8'h3C, 0, 0, 8, 0);
         begin
            repeat (30) @(posedge CLK);
            #2 Prescale = 6'd32;
         end
      join
      send_frame(32, 1, 8'hC5, 0, 0, 32, 1);
      wait_idle();

      chk("sb_empty", sb.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout got=%0d exp=0", cyc);
      $fatal(1, "timeout");
   end

endmodule
